// File: rtl/phy_rx_deser.sv
// -----------------------------------------------------------------------------
// phy_rx_deser
// Receive-side deserializer for the PHY link. Consumes the serial stream
// (MSB first, one bit per clk_32f), locks byte alignment on a run of
// BC_NEEDED consecutive COM symbols, then strips COM/IDLE fillers and hands
// each data byte to the lane demux with a one-cycle valid_out pulse.
//
// Optional build macro: PHY_RX_STATS_EN
//   When defined, adds the rx_count[15:0] output: a saturating count of
//   delivered data bytes, cleared only by reset_L.
// -----------------------------------------------------------------------------
module phy_rx_deser #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter logic [7:0] IDLE      = 8'h7C,
  parameter int         BC_NEEDED = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active,
  output logic        idle_out
`ifdef PHY_RX_STATS_EN
  ,
  output logic [15:0] rx_count
`endif
);

  // Number of aligned COMs that completes acquisition, in the counter's width.
  localparam logic [3:0] BC_TARGET = 4'(BC_NEEDED);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    ALIGN  = 2'b01,
    ACTIVE = 2'b10
  } state_t;

  state_t      state_r;
  logic [7:0]  sh_r;
  logic [2:0]  bit_cnt_r;
  logic [3:0]  bc_cnt_r;

  logic [7:0]  cand_s;
  logic        byte_done_s;
  logic        is_com_s;
  logic        is_idle_s;
  logic        deliver_s;
  logic        bc_last_s;

  // Candidate symbol, byte boundary and symbol classification for this cycle.
  always_comb begin
    cand_s      = {sh_r[6:0], data_in};
    is_com_s    = (cand_s == COM);
    is_idle_s   = (cand_s == IDLE);
    bc_last_s   = ((bc_cnt_r + 4'd1) == BC_TARGET);
    if (state_r != SEARCH) begin
      byte_done_s = (bit_cnt_r == 3'd7);
    end else begin
      byte_done_s = 1'b0;
    end
    if ((state_r == ACTIVE) && byte_done_s && !is_com_s && !is_idle_s) begin
      deliver_s = 1'b1;
    end else begin
      deliver_s = 1'b0;
    end
  end

  // Serial shift register: slides one bit per clock in every state.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sh_r <= 8'h00;
    end else begin
      sh_r <= cand_s;
    end
  end

  // Alignment FSM with registered link outputs.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_r   <= SEARCH;
      bit_cnt_r <= 3'd0;
      bc_cnt_r  <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      idle_out  <= 1'b0;
    end else begin
      // valid_out is a single-cycle strobe; only a delivered byte raises it.
      valid_out <= 1'b0;
      case (state_r)
        SEARCH: begin
          // Outputs stay at their reset values until the link is aligned.
          data_out <= 8'h00;
          active   <= 1'b0;
          idle_out <= 1'b0;
          bit_cnt_r <= 3'd0;
          if (is_com_s) begin
            // Bit-sliding hit: the next bit starts a fresh byte.
            bc_cnt_r <= 4'd1;
            state_r  <= ALIGN;
          end else begin
            bc_cnt_r <= 4'd0;
            state_r  <= SEARCH;
          end
        end

        ALIGN: begin
          active <= 1'b0;
          if (byte_done_s) begin
            if (is_com_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              bc_cnt_r  <= bc_cnt_r + 4'd1;
              if (bc_last_s) begin
                state_r <= ACTIVE;
                active  <= 1'b1;
              end else begin
                state_r <= ALIGN;
              end
            end else begin
              // Alignment broken: restart the bit-sliding search.
              bit_cnt_r <= 3'd0;
              bc_cnt_r  <= 4'd0;
              state_r   <= SEARCH;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            state_r   <= ALIGN;
          end
        end

        ACTIVE: begin
          // Locked for good: only reset_L leaves this state.
          active    <= 1'b1;
          bit_cnt_r <= bit_cnt_r + 3'd1;
          state_r   <= ACTIVE;
          if (byte_done_s) begin
            if (is_com_s) begin
              idle_out <= 1'b0;
            end else if (is_idle_s) begin
              idle_out <= 1'b1;
            end else begin
              data_out  <= cand_s;
              valid_out <= 1'b1;
              idle_out  <= 1'b0;
            end
          end else begin
            idle_out <= idle_out;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean search.
          state_r   <= SEARCH;
          bit_cnt_r <= 3'd0;
          bc_cnt_r  <= 4'd0;
          data_out  <= 8'h00;
          active    <= 1'b0;
          idle_out  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHY_RX_STATS_EN
  // Saturating count of delivered data bytes, updated with each valid pulse.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      rx_count <= 16'h0000;
    end else if (deliver_s && (rx_count != 16'hFFFF)) begin
      rx_count <= rx_count + 16'd1;
    end else begin
      rx_count <= rx_count;
    end
  end
`endif

endmodule
